// File: rtl/rv32i_pkg.sv
// Shared RV32 definitions: M-extension funct3 encodings (also used by the decoder)
// and the state encoding of the iterative multiply/divide unit.
package rv32i_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_CALC = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = MD_IDLE,
    ST_CALC = MD_CALC,
    ST_FIX  = MD_FIX
  } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one iteration per cycle, sign correction in a final FIX cycle.
module muldiv_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  muldiv_op_e        op_q, op_d, op_in;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic              sgn_a_in, sgn_b_in, div_zero, div_ovf;
  logic [XLEN:0]     part, diff, sum;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    op_in    = muldiv_op_e'(op);
    sgn_a_in = ((op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                (op_in == OP_DIV)  || (op_in == OP_REM)) && A[XLEN-1];
    sgn_b_in = ((op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM)) && B[XLEN-1];
    div_zero = (B == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) && (A == MIN_NEG) && (B == '1);

    part     = acc_q[2*XLEN-1:XLEN-1];
    diff     = part - {1'b0, opnd_q};
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    prod_fix = cneg2(acc_q, sa_q ^ sb_q);
    quo_fix  = cneg(acc_q[XLEN-1:0], sa_q ^ sb_q);
    rem_fix  = cneg(acc_q[2*XLEN-1:XLEN], sa_q);

    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op_in;
          sa_d  = sgn_a_in;
          sb_d  = sgn_b_in;
          cnt_d = '0;
          if (op_in[2] && (div_zero || div_ovf)) begin
            // Architectural special cases resolve without iterating
            done_d = 1'b1;
            if (div_zero) result_d = op_in[1] ? A : '1;
            else          result_d = op_in[1] ? '0 : MIN_NEG;
          end else if (op_in[2]) begin
            state_d = ST_CALC;
            acc_d   = {{XLEN{1'b0}}, cneg(A, sgn_a_in)};
            opnd_d  = cneg(B, sgn_b_in);
          end else begin
            state_d = ST_CALC;
            acc_d   = {{XLEN{1'b0}}, cneg(B, sgn_b_in)};
            opnd_d  = cneg(A, sgn_a_in);
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) state_d = ST_FIX;
        if (op_q[2]) begin
          // A clear top bit of diff means the trial subtraction did not borrow
          if (!diff[XLEN]) acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else             acc_d = {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
          acc_d = {sum, acc_q[XLEN-1:1]};
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (op_q[2])              result_d = op_q[1] ? rem_fix : quo_fix;
        else if (op_q == OP_MUL)  result_d = prod_fix[XLEN-1:0];
        else                      result_d = prod_fix[2*XLEN-1:XLEN];
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    sa_q   <= sa_d;
    sb_q   <= sb_d;
    opnd_q <= opnd_d;
    acc_q  <= acc_d;
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M vectors, randomized ops against a 64-bit
// integer reference model, reset abort, ignored start while busy and back-to-back issue.
module tb_muldiv_unit;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op_s = 3'd0;
  logic [31:0] a_s = 32'd0;
  logic [31:0] b_s = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op_s), .A(a_s), .B(b_s),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      ps;
    logic [63:0] pv;
    int          sa, sb, q;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin ps = longint'(sa) * longint'(sb); pv = ps; return pv[31:0]; end
      3'd1: begin ps = longint'(sa) * longint'(sb); pv = ps; return pv[63:32]; end
      3'd2: begin ps = longint'(sa) * longint'({32'h0, b}); pv = ps; return pv[63:32]; end
      3'd3: begin pv = {32'h0, a} * {32'h0, b}; return pv[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; return q;
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; return q;
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 32'h0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom % 16;
      4: return -($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  // Issues one op with a single-cycle start pulse, scrambles A/B afterwards, and
  // reports result, done latency (-1 on timeout) and whether busy followed the schedule.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit busy_ok);
    bit fast;
    fast = (model_lat(op, a, b) == 1);
    @(negedge clk);
    start = 1'b1; op_s = op; a_s = a; b_s = b;
    @(posedge clk);
    #1 start = 1'b0; a_s = $urandom; b_s = $urandom;
    lat = -1; res = 32'hx; busy_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (busy !== (fast ? 1'b0 : (c <= 33))) busy_ok = 1'b0;
      if (done === 1'b1) begin lat = c; res = result; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [10] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] as  [10] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -32'd20, -32'd20,
                              32'd20, 32'd20, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [10] = '{-32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd3,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [10] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
                              32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd20, 32'h8000_0000, 32'h0};
    int          elat [10] = '{34, 34, 34, 34, 34, 34, 1, 1, 1, 1};
    logic [31:0] res;
    int          lat;
    bit          bok;
    for (int i = 0; i < 10; i++) begin
      do_op(ops[i], as[i], bs[i], res, lat, bok);
      total++; if (res !== exp[i]) begin bad++; $display("FAIL dir_result[%0d] got=%h want=%h", i, res, exp[i]); end
      total++; if (lat != elat[i]) begin bad++; $display("FAIL dir_latency[%0d] got=%0d want=%0d", i, lat, elat[i]); end
      total++; if (!bok) begin bad++; $display("FAIL dir_busy[%0d] got=wrong_schedule want=ok", i); end
      if (i == 0) begin
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b want=0", done); end
        total++; if (result !== exp[0]) begin bad++; $display("FAIL result_hold got=%h want=%h", result, exp[0]); end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, res, exp;
    int          lat;
    bit          bok;
    for (int i = 0; i < 48; i++) begin
      op = 3'(i % 8);
      a = pick();
      b = pick();
      exp = model(op, a, b);
      do_op(op, a, b, res, lat, bok);
      total++; if (res !== exp) begin bad++; $display("FAIL rnd_result op=%0d a=%h b=%h got=%h want=%h", op, a, b, res, exp); end
      total++; if (lat != model_lat(op, a, b)) begin bad++; $display("FAIL rnd_latency op=%0d got=%0d want=%0d", op, lat, model_lat(op, a, b)); end
      total++; if (!bok) begin bad++; $display("FAIL rnd_busy op=%0d got=wrong_schedule want=ok", op); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int          lat;
    bit          bok, seen;
    @(negedge clk);
    start = 1'b1; op_s = 3'd4; a_s = 32'd1000; b_s = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL midrst_result got=%h want=0", result); end
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL midrst_abandon got=activity want=idle"); end
    do_op(3'd5, 32'd100, 32'd7, res, lat, bok);
    total++; if (res !== 32'd14) begin bad++; $display("FAIL midrst_divu got=%h want=%h", res, 32'd14); end
    total++; if (lat != 34) begin bad++; $display("FAIL midrst_latency got=%0d want=34", lat); end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] res, exp;
    int          lat;
    exp = model(3'd0, 32'h1234_5678, 32'h0000_0ABC);
    @(negedge clk);
    start = 1'b1; op_s = 3'd0; a_s = 32'h1234_5678; b_s = 32'h0000_0ABC;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; res = 32'hx;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 5) begin start = 1'b1; op_s = 3'd5; a_s = 32'd55; b_s = 32'd0; end
      if (c == 7) start = 1'b0;
      if (done === 1'b1) begin lat = c; res = result; break; end
    end
    start = 1'b0;
    total++; if (res !== exp) begin bad++; $display("FAIL busy_start_result got=%h want=%h", res, exp); end
    total++; if (lat != 34) begin bad++; $display("FAIL busy_start_latency got=%0d want=34", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, res;
    int          lat;
    a1 = $urandom; b1 = $urandom | 32'h1;
    a2 = $urandom; b2 = ($urandom % 1000) + 1;
    @(negedge clk);
    start = 1'b1; op_s = 3'd1; a_s = a1; b_s = b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = c; res = result; break; end
    end
    total++; if (res !== model(3'd1, a1, b1)) begin bad++; $display("FAIL b2b_first got=%h want=%h", res, model(3'd1, a1, b1)); end
    start = 1'b1; op_s = 3'd6; a_s = a2; b_s = b2;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; res = 32'hx;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = c; res = result; break; end
    end
    total++; if (res !== model(3'd6, a2, b2)) begin bad++; $display("FAIL b2b_second got=%h want=%h", res, model(3'd6, a2, b2)); end
    total++; if (lat != 34) begin bad++; $display("FAIL b2b_latency got=%0d want=34", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
